// File: rtl/sm_hex_display_n.sv
// Multiplexed hex seven-segment scanner: LZ blanking, dot/enable masks, 16-level PWM.
// Latency: outputs registered, one clock after the (idx, sub) scan state is reached.
// Backpressure: none; free-running scan, inputs sampled once per frame.
module sm_hex_display_n #(
  parameter int DIGITS           = 8,
  parameter int PRESCALE         = 1024,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dots,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic [6:0]            seven_segments,
  output logic                  dot,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  logic [PW-1:0]         presc;
  logic [3:0]            sub;
  logic [IW-1:0]         idx;
  logic                  primed;

  logic [4*DIGITS-1:0]   snap_number;
  logic [DIGITS-1:0]     snap_dots;
  logic [DIGITS-1:0]     snap_en;
  logic                  snap_blz;
  logic [3:0]            snap_bright;

  logic                  tick;
  logic                  frame_wrap;
  logic                  load;

  assign tick       = (presc == PRESC_MAX);
  assign frame_wrap = tick && (sub == 4'hF) && (idx == IDX_MAX);
  // First tick after reset also loads, so the display never waits a full frame of darkness.
  assign load       = tick && (frame_wrap || !primed);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      sub         <= '0;
      idx         <= '0;
      primed      <= 1'b0;
      snap_number <= '0;
      snap_dots   <= '0;
      snap_en     <= '0;
      snap_blz    <= 1'b0;
      snap_bright <= '0;
    end else begin
      if (tick) begin
        presc <= '0;
        sub   <= sub + 4'd1;
        if (sub == 4'hF) begin
          idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end
      end else begin
        presc <= presc + PW'(1);
      end
      if (load) begin
        primed      <= 1'b1;
        snap_number <= number;
        snap_dots   <= dots;
        snap_en     <= digit_en;
        snap_blz    <= blank_lz;
        snap_bright <= brightness;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  logic [DIGITS-1:0] zero_upper;
  logic [DIGITS-1:0] visible;
  logic              zero_run;

  // zero_upper[i]: nibbles i..DIGITS-1 are all zero.
  always_comb begin
    zero_run   = 1'b1;
    zero_upper = '0;
    visible    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (snap_number[4*i +: 4] == 4'h0);
      zero_upper[i] = zero_run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      visible[i] = snap_en[i] & ~(snap_blz & (i > 0) & zero_upper[i]);
    end
  end

  logic [3:0]        cur_nib;
  logic              cur_dot;
  logic              cur_vis;
  logic              lit;
  logic [6:0]        seg_raw;
  logic              dot_raw;
  logic [DIGITS-1:0] an_raw;

  always_comb begin
    cur_nib = 4'h0;
    cur_dot = 1'b0;
    cur_vis = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = snap_number[4*i +: 4];
        cur_dot = snap_dots[i];
        cur_vis = visible[i];
      end
    end
    lit     = cur_vis && (sub < snap_bright);
    seg_raw = lit ? hex7(cur_nib) : 7'h00;
    dot_raw = lit & cur_dot;
    an_raw  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      an_raw[i] = lit & (idx == IW'(i));
    end
  end

  // Anodes are decoded from a single registered idx, so only one can ever be active.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seven_segments <= {7{SEG_ACTIVE_LOW}};
      dot            <= SEG_ACTIVE_LOW;
      anodes         <= {DIGITS{ANODE_ACTIVE_LOW}};
      frame_done     <= 1'b0;
    end else begin
      seven_segments <= seg_raw ^ {7{SEG_ACTIVE_LOW}};
      dot            <= dot_raw ^ SEG_ACTIVE_LOW;
      anodes         <= an_raw ^ {DIGITS{ANODE_ACTIVE_LOW}};
      frame_done     <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_sm_hex_display_n.sv
// Directed bench for sm_hex_display_n: default 8-digit active-low instance plus
// a 4-digit, prescale-3, active-high instance.
module tb_sm_hex_display_n;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] number;
  logic [7:0]  dots, digit_en;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [6:0]  seven_segments;
  logic        dot;
  logic [7:0]  anodes;
  logic        frame_done;

  logic [15:0] number2;
  logic [3:0]  dots2, en2, br2;
  logic        blz2;
  logic [6:0]  seg2;
  logic        dot2;
  logic [3:0]  an2;
  logic        fd2;

  sm_hex_display_n #(.DIGITS(8), .PRESCALE(1), .SEG_ACTIVE_LOW(1'b1), .ANODE_ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .number(number), .dots(dots), .digit_en(digit_en),
    .blank_lz(blank_lz), .brightness(brightness), .seven_segments(seven_segments),
    .dot(dot), .anodes(anodes), .frame_done(frame_done)
  );

  sm_hex_display_n #(.DIGITS(4), .PRESCALE(3), .SEG_ACTIVE_LOW(1'b0), .ANODE_ACTIVE_LOW(1'b0)) dut2 (
    .clock(clock), .reset(reset), .number(number2), .dots(dots2), .digit_en(en2),
    .blank_lz(blz2), .brightness(br2), .seven_segments(seg2),
    .dot(dot2), .anodes(an2), .frame_done(fd2)
  );

  int errors = 0;
  int checks = 0;
  int cnt[8];
  int dcnt[8];
  logic [6:0] seg_seen[8];
  int viol;

  localparam logic [55:0] BASIC_SEGS = {7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_done && n < 1000);
    check("frame_done_seen", {31'd0, frame_done}, 32'd1);
  endtask

  // One frame of the 8-digit instance, starting right after a frame_done sample.
  task automatic capture(input int br, input int chg_at, input logic [31:0] chg_val);
    logic [7:0] act;
    logic [6:0] sa;
    logic       da;
    viol = 0;
    for (int j = 0; j < 8; j++) begin
      cnt[j] = 0;
      dcnt[j] = 0;
      seg_seen[j] = 7'h00;
    end
    for (int s = 0; s < 128; s++) begin
      @(negedge clock);
      act = ~anodes;
      sa  = ~seven_segments;
      da  = ~dot;
      if ($countones(act) > 1) viol++;
      for (int j = 0; j < 8; j++) begin
        if (act[j]) begin
          if (j != s / 16 || (s % 16) >= br) viol++;
          cnt[j]++;
          if (cnt[j] == 1) seg_seen[j] = sa;
          else if (seg_seen[j] != sa) viol++;
          if (da) dcnt[j]++;
        end
      end
      if (act == 8'h00 && (sa != 7'h00 || da)) viol++;
      if (frame_done != (s == 127)) viol++;
      if (s == chg_at) number = chg_val;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] vis, input int duty,
                             input logic [55:0] segs, input logic [7:0] dmask);
    check({tag, "_viol"}, viol, 0);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("%s_cnt%0d", tag, j), cnt[j], vis[j] ? duty : 0);
      check($sformatf("%s_dot%0d", tag, j), dcnt[j], (vis[j] && dmask[j]) ? duty : 0);
      if (vis[j] && duty > 0)
        check($sformatf("%s_seg%0d", tag, j), {25'd0, seg_seen[j]}, {25'd0, segs[7*j +: 7]});
    end
  endtask

  initial begin
    int n2, c0, c3, bad;
    number = 32'h0123_4567; dots = 8'h00; digit_en = 8'hFF; blank_lz = 1'b0; brightness = 4'd15;
    number2 = 16'h8888; dots2 = 4'h0; en2 = 4'hF; blz2 = 1'b0; br2 = 4'd15;

    #2 reset = 1'b1;
    #1;
    check("rst_anodes", anodes, 32'hFF);
    check("rst_segs", seven_segments, 32'h7F);
    check("rst_dot", dot, 1);
    check("rst_fd", frame_done, 0);
    check("rst_an2", an2, 0);
    check("rst_seg2", seg2, 0);
    check("rst_dot2", dot2, 0);

    @(negedge clock) reset = 1'b0;
    repeat (88) @(negedge clock);
    check("scan_d5_anode", anodes, 32'hDF);
    check("scan_d5_seg", seven_segments, 32'h24);

    reset = 1'b1;
    #1;
    check("midrst_anodes", anodes, 32'hFF);
    check("midrst_segs", seven_segments, 32'h7F);
    check("midrst_dot", dot, 1);
    check("midrst_fd", frame_done, 0);
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    check("restart_dark", anodes, 32'hFF);
    @(negedge clock);
    check("restart_d0_anode", anodes, 32'hFE);
    check("restart_d0_seg", seven_segments, 32'h78);

    wait_fd();
    capture(15, -1, 32'h0);
    check_frame("basic", 8'hFF, 15, BASIC_SEGS, 8'h00);

    number = 32'h0000_00A0; blank_lz = 1'b1;
    wait_fd(); capture(15, -1, 32'h0);
    check_frame("lz_on", 8'h03, 15, {42'h0, 7'h77, 7'h3F}, 8'h00);

    blank_lz = 1'b0;
    wait_fd(); capture(15, -1, 32'h0);
    check_frame("lz_off", 8'hFF, 15, {{6{7'h3F}}, 7'h77, 7'h3F}, 8'h00);

    number = 32'h0; blank_lz = 1'b1;
    wait_fd(); capture(15, -1, 32'h0);
    check_frame("lz_zero", 8'h01, 15, {8{7'h3F}}, 8'h00);

    number = 32'h0123_4567; blank_lz = 1'b0; brightness = 4'd4;
    wait_fd(); capture(4, -1, 32'h0);
    check_frame("bright4", 8'hFF, 4, BASIC_SEGS, 8'h00);

    brightness = 4'd0;
    wait_fd(); capture(0, -1, 32'h0);
    check_frame("bright0", 8'hFF, 0, BASIC_SEGS, 8'h00);

    brightness = 4'd15; digit_en = 8'h0F; dots = 8'h01;
    wait_fd(); capture(15, -1, 32'h0);
    check_frame("en_dots", 8'h0F, 15, BASIC_SEGS, 8'h01);

    digit_en = 8'hFF; dots = 8'h00; number = 32'h1111_1111;
    wait_fd(); capture(15, 48, 32'h2222_2222);
    check_frame("snap_old", 8'hFF, 15, {8{7'h06}}, 8'h00);
    capture(15, -1, 32'h0);
    check_frame("snap_new", 8'hFF, 15, {8{7'h5B}}, 8'h00);

    n2 = 0;
    do begin @(negedge clock); n2++; end while (!fd2 && n2 < 1000);
    check("p_fd2_seen", {31'd0, fd2}, 1);
    n2 = 0; c0 = 0; c3 = 0; bad = 0;
    do begin
      @(negedge clock);
      n2++;
      if (an2 == 4'b0001) c0++;
      if (an2 == 4'b1000) c3++;
      if (an2 != 4'h0 && (seg2 != 7'h7F || $countones(an2) != 1)) bad++;
      if (an2 == 4'h0 && seg2 != 7'h00) bad++;
      if (dot2) bad++;
    end while (!fd2 && n2 < 1000);
    check("p_frame_period", n2, 192);
    check("p_d0_cycles", c0, 45);
    check("p_d3_cycles", c3, 45);
    check("p_bad_cycles", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
